instruction_memory_encoder: RTL and testbench

- Reverse of the instruction-word decode path. Accepts instruction fields over a valid/ready handshake: opcode, instruction type, register addresses and an 8-bit immediate.
- Packs the fields into a dataLength-bit memory word using the same bit layout the decode path splits apart.
- Writes each word into program RAM at consecutive addresses through a write/ack handshake.
- Serves as the program loader in front of RAM during boot/test. Stops on `HALT or when memory is full.

---
 rtl/instruction_memory_encoder_if.sv | 81 ++++++++
 rtl/instruction_memory_encoder.sv | 178 +++++++++++++++++
 tb/tb_instruction_memory_encoder.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/instruction_memory_encoder_if.sv
// Field/RAM bus for the instruction memory encoder (program loader).
// Default widths and type/opcode codes are defined here when no
// project-wide header has already provided them.
// Ports: none. Signals carry the field handshake (in_valid/in_ready,
// opcode, inst_type, reg1_add, reg2_add, imm8) and the RAM side
// (mem_we, mem_re, mem_addr, mem_data, mem_ack, mem_rdata).
// Modports: master = encoder, slave = source/RAM environment.

`ifndef dataLength
`define dataLength 16
`endif
`ifndef instructionLength
`define instructionLength 7
`endif
`ifndef instructionTypeLength
`define instructionTypeLength 3
`endif
`ifndef totalAddressLength
`define totalAddressLength 4
`endif
`ifndef ramAddressLength
`define ramAddressLength 8
`endif
`ifndef OPR1R2
`define OPR1R2 3'd0
`endif
`ifndef OPR1
`define OPR1 3'd1
`endif
`ifndef OPD8
`define OPD8 3'd2
`endif
`ifndef OP
`define OP 3'd3
`endif
`ifndef ADD
`define ADD 7'h01
`endif
`ifndef INC
`define INC 7'h05
`endif
`ifndef LDIL
`define LDIL 7'h10
`endif
`ifndef HALT
`define HALT 7'h7F
`endif

interface instruction_memory_encoder_if #(
    parameter int dataLength            = `dataLength,
    parameter int instructionLength     = `instructionLength,
    parameter int instructionTypeLength = `instructionTypeLength,
    parameter int totalAddressLength    = `totalAddressLength,
    parameter int ramAddrLength         = `ramAddressLength
);
    logic                             in_valid;
    logic                             in_ready;
    logic [instructionLength-1:0]     opcode;
    logic [instructionTypeLength-1:0] inst_type;
    logic [totalAddressLength-1:0]    reg1_add;
    logic [totalAddressLength-1:0]    reg2_add;
    logic [7:0]                       imm8;
    logic                             mem_we;
    logic                             mem_re;
    logic [ramAddrLength-1:0]         mem_addr;
    logic [dataLength-1:0]            mem_data;
    logic                             mem_ack;
    logic [dataLength-1:0]            mem_rdata;

    modport master (
        input  in_valid, opcode, inst_type, reg1_add, reg2_add, imm8,
        input  mem_ack, mem_rdata,
        output in_ready, mem_we, mem_re, mem_addr, mem_data
    );

    modport slave (
        output in_valid, opcode, inst_type, reg1_add, reg2_add, imm8,
        output mem_ack, mem_rdata,
        input  in_ready, mem_we, mem_re, mem_addr, mem_data
    );
endinterface

// File: rtl/instruction_memory_encoder.sv
// Program loader: packs instruction fields into RAM words and writes them
// to consecutive addresses until HALT or the last RAM location.
// Ports: clk, rst (sync, active high), start pulse, base_addr, bus (field
// handshake + RAM write/read handshake), busy, done pulse, sticky err,
// word_count. Optional readback check: ENCODER_READBACK_VERIFY_EN.

module instruction_memory_encoder #(
    parameter int dataLength            = `dataLength,
    parameter int instructionLength     = `instructionLength,
    parameter int instructionTypeLength = `instructionTypeLength,
    parameter int totalAddressLength    = `totalAddressLength,
    parameter int ramAddrLength         = `ramAddressLength
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [ramAddrLength-1:0]   base_addr,
    instruction_memory_encoder_if.master bus,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [ramAddrLength:0]     word_count
);

    localparam int OP_LSB = dataLength - instructionLength;
    localparam int R1_MSB = OP_LSB - 1;
    localparam int R2_MSB = OP_LSB - totalAddressLength - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCEPT,
        S_WRITE,
        S_VERIFY,
        S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [ramAddrLength-1:0] addr_q, addr_d;
    logic [dataLength-1:0]    word_q, word_d;
    logic                     halt_q, halt_d;
    logic [ramAddrLength:0]   count_q, count_d;
    logic                     err_q, err_d;
    logic                     done_q, done_d;

    logic [dataLength-1:0]    word_enc;
    logic                     type_ok;
    logic                     advance;

    // Field packing: opcode on top, type-dependent fields below, rest 0.
    always_comb begin
        word_enc = '0;
        type_ok  = 1'b1;
        word_enc[dataLength-1 -: instructionLength] = bus.opcode;
        case (bus.inst_type)
            `OPR1R2: begin
                word_enc[R1_MSB -: totalAddressLength] = bus.reg1_add;
                word_enc[R2_MSB -: totalAddressLength] = bus.reg2_add;
            end
            `OPR1: word_enc[R1_MSB -: totalAddressLength] = bus.reg1_add;
            `OPD8: word_enc[R1_MSB -: 8] = bus.imm8;
            `OP:   ;
            default: type_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        word_d  = word_q;
        halt_d  = halt_q;
        count_d = count_q;
        err_d   = err_q;
        done_d  = 1'b0;
        advance = 1'b0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    addr_d  = base_addr;
                    count_d = '0;
                    err_d   = 1'b0;
                    state_d = S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                if (bus.in_valid) begin
                    if (type_ok) begin
                        word_d  = word_enc;
                        halt_d  = (bus.opcode == `HALT);
                        state_d = S_WRITE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_WRITE: begin
                if (bus.mem_ack) begin
                    count_d = count_q + 1'b1;
`ifdef ENCODER_READBACK_VERIFY_EN
                    state_d = S_VERIFY;
`else
                    advance = 1'b1;
`endif
                end
            end
            S_VERIFY: begin
`ifdef ENCODER_READBACK_VERIFY_EN
                if (bus.mem_ack) begin
                    if (bus.mem_rdata != word_q) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        advance = 1'b1;
                    end
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase

        // Word committed: finish on HALT, stop at the top of RAM, else next.
        if (advance) begin
            if (halt_q) begin
                done_d  = 1'b1;
                state_d = S_DONE;
            end else if (&addr_q) begin
                err_d   = 1'b1;
                state_d = S_DONE;
            end else begin
                addr_d  = addr_q + 1'b1;
                state_d = S_ACCEPT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            word_q  <= '0;
            halt_q  <= 1'b0;
            count_q <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            halt_q  <= halt_d;
            count_q <= count_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    assign bus.in_ready = (state_q == S_ACCEPT);
    assign bus.mem_we   = (state_q == S_WRITE);
    assign bus.mem_addr = addr_q;
    assign bus.mem_data = word_q;

`ifdef ENCODER_READBACK_VERIFY_EN
    assign bus.mem_re = (state_q == S_VERIFY);
`else
    logic unused_rdata;
    assign bus.mem_re   = 1'b0;
    assign unused_rdata = ^bus.mem_rdata;
`endif

    assign busy       = (state_q == S_ACCEPT) || (state_q == S_WRITE)
                     || (state_q == S_VERIFY);
    assign done       = done_q;
    assign err        = err_q;
    assign word_count = count_q;

endmodule

// File: tb/tb_instruction_memory_encoder.sv
// Directed self-checking bench for instruction_memory_encoder.
// Expected RAM words are hand-packed 16-bit constants.

module tb_instruction_memory_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] base_addr;
    logic       busy;
    logic       done;
    logic       err;
    logic [8:0] word_count;

    int total = 0;
    int fails = 0;

    instruction_memory_encoder_if bus ();

    instruction_memory_encoder dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Acknowledge the pending write (and the readback when enabled).
    task automatic do_ack(input logic [15:0] rdata);
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
`ifdef ENCODER_READBACK_VERIFY_EN
        chk("verify_re", {31'd0, bus.mem_re}, 32'd1);
        bus.mem_rdata = rdata;
        bus.mem_ack   = 1'b1;
        tick();
        bus.mem_ack   = 1'b0;
`else
        bus.mem_rdata = rdata;
`endif
    endtask

    task automatic send(input logic [6:0] op, input logic [2:0] ty,
                        input logic [3:0] r1, input logic [3:0] r2,
                        input logic [7:0] imm);
        bus.opcode    = op;
        bus.inst_type = ty;
        bus.reg1_add  = r1;
        bus.reg2_add  = r2;
        bus.imm8      = imm;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_we"},    {31'd0, bus.mem_we},   32'd0);
        chk({tag, "_re"},    {31'd0, bus.mem_re},   32'd0);
        chk({tag, "_addr"},  {24'd0, bus.mem_addr}, 32'd0);
        chk({tag, "_data"},  {16'd0, bus.mem_data}, 32'd0);
        chk({tag, "_rdy"},   {31'd0, bus.in_ready}, 32'd0);
        chk({tag, "_busy"},  {31'd0, busy},         32'd0);
        chk({tag, "_done"},  {31'd0, done},         32'd0);
        chk({tag, "_err"},   {31'd0, err},          32'd0);
        chk({tag, "_count"}, {23'd0, word_count},   32'd0);
    endtask

    task automatic do_start(input logic [7:0] base);
        base_addr = base;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        base_addr     = '0;
        bus.in_valid  = 1'b0;
        bus.opcode    = '0;
        bus.inst_type = '0;
        bus.reg1_add  = '0;
        bus.reg2_add  = '0;
        bus.imm8      = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk_all_zero("reset");

        // ADD r3,r5 at 0x10
        do_start(8'h10);
        chk("acc_rdy",  {31'd0, bus.in_ready}, 32'd1);
        chk("acc_busy", {31'd0, busy},         32'd1);
        chk("acc_addr", {24'd0, bus.mem_addr}, 32'h10);
        send(`ADD, `OPR1R2, 4'h3, 4'h5, 8'h00);
        chk("add_we",   {31'd0, bus.mem_we},   32'd1);
        chk("add_addr", {24'd0, bus.mem_addr}, 32'h10);
        chk("add_data", {16'd0, bus.mem_data}, 32'h026A);
        chk("add_rdy",  {31'd0, bus.in_ready}, 32'd0);
        do_ack(16'h026A);
        chk("add_cnt",  {23'd0, word_count},   32'd1);
        chk("add_we0",  {31'd0, bus.mem_we},   32'd0);
        chk("add_next", {24'd0, bus.mem_addr}, 32'h11);

        // LDIL 0xA5 with ack held off for 3 cycles
        send(`LDIL, `OPD8, 4'hF, 4'hF, 8'hA5);
        for (int i = 0; i < 3; i++) begin
            chk("ldil_we",   {31'd0, bus.mem_we},   32'd1);
            chk("ldil_addr", {24'd0, bus.mem_addr}, 32'h11);
            chk("ldil_data", {16'd0, bus.mem_data}, 32'h214A);
            tick();
        end
        chk("ldil_hold", {31'd0, bus.mem_we}, 32'd1);
        do_ack(16'h214A);
        chk("ldil_cnt", {23'd0, word_count}, 32'd2);

        // HALT ends the program with a single done pulse
        send(`HALT, `OP, 4'h7, 4'h9, 8'h33);
        chk("halt_data", {16'd0, bus.mem_data}, 32'hFE00);
        chk("halt_addr", {24'd0, bus.mem_addr}, 32'h12);
        do_ack(16'hFE00);
        chk("halt_done", {31'd0, done},         32'd1);
        chk("halt_busy", {31'd0, busy},         32'd0);
        chk("halt_rdy",  {31'd0, bus.in_ready}, 32'd0);
        chk("halt_err",  {31'd0, err},          32'd0);
        chk("halt_cnt",  {23'd0, word_count},   32'd3);
        tick();
        chk("halt_pulse", {31'd0, done}, 32'd0);

        // Last location: write at 0xFF then stop with err
        do_start(8'hFF);
        chk("full_cnt0", {23'd0, word_count}, 32'd0);
        send(`INC, `OPR1, 4'h2, 4'hC, 8'hFF);
        bus.opcode    = `ADD;
        bus.inst_type = `OPR1R2;
        bus.in_valid  = 1'b1;
        chk("full_data", {16'd0, bus.mem_data}, 32'h0A40);
        chk("full_addr", {24'd0, bus.mem_addr}, 32'hFF);
        do_ack(16'h0A40);
        chk("full_err",  {31'd0, err},          32'd1);
        chk("full_done", {31'd0, done},         32'd0);
        chk("full_rdy",  {31'd0, bus.in_ready}, 32'd0);
        chk("full_busy", {31'd0, busy},         32'd0);
        chk("full_wrap", {24'd0, bus.mem_addr}, 32'hFF);
        tick();
        chk("full_nowe", {31'd0, bus.mem_we},   32'd0);
        chk("full_cnt",  {23'd0, word_count},   32'd1);
        bus.in_valid = 1'b0;

        // Illegal type: nothing written, err, DONE
        do_start(8'h20);
        chk("ill_errclr", {31'd0, err}, 32'd0);
        send(`ADD, 3'd5, 4'h1, 4'h1, 8'h00);
        chk("ill_we",   {31'd0, bus.mem_we},   32'd0);
        chk("ill_err",  {31'd0, err},          32'd1);
        chk("ill_busy", {31'd0, busy},         32'd0);
        chk("ill_done", {31'd0, done},         32'd0);
        chk("ill_cnt",  {23'd0, word_count},   32'd0);
        tick();
        chk("ill_we2",  {31'd0, bus.mem_we},   32'd0);

        // Reset while a write waits for ack
        do_start(8'h30);
        send(`INC, `OPR1, 4'h4, 4'h0, 8'h00);
        chk("rst_pre_we", {31'd0, bus.mem_we}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_all_zero("rst_mid");
        bus.in_valid = 1'b1;
        tick();
        chk("idle_rdy", {31'd0, bus.in_ready}, 32'd0);
        chk("idle_we",  {31'd0, bus.mem_we},   32'd0);
        chk("idle_busy", {31'd0, busy},        32'd0);
        bus.in_valid = 1'b0;

`ifdef ENCODER_READBACK_VERIFY_EN
        // Corrupt readback: err, no done pulse
        do_start(8'h40);
        send(`ADD, `OPR1R2, 4'h3, 4'h5, 8'h00);
        do_ack(16'h026B);
        chk("vfy_err",  {31'd0, err},  32'd1);
        chk("vfy_done", {31'd0, done}, 32'd0);
        chk("vfy_busy", {31'd0, busy}, 32'd0);
`endif

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
